// File: rtl/wr_chunk_sequencer.sv
// wr_chunk_sequencer: splits a host write job into engine-sized chunks and sequences the write engine
module wr_chunk_sequencer #(
  parameter int unsigned ADDR_W    = 42,
  parameter int unsigned MAX_CHUNK = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] job_clAddr,
  input  logic [63:0]       job_len,
  input  logic              abort,
  output logic              busy,
  output logic              job_done,
  output logic              job_aborted,
  output logic [31:0]       chunks_done,
  output logic              eng_run,
  output logic [ADDR_W-1:0] eng_clAddr,
  output logic [63:0]       eng_len,
  input  logic              eng_done
);
  localparam logic [63:0] MAX_LEN = 64'(MAX_CHUNK);
  typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, WAIT, FINISH} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, eng_addr_q, eng_addr_d;
  logic [63:0]       remain_q, remain_d, eng_len_q, eng_len_d;
  logic [31:0]       chunks_q, chunks_d;
  logic              eng_run_q, eng_run_d, job_done_q, job_done_d, job_aborted_q, job_aborted_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      eng_addr_q    <= '0;
      remain_q      <= '0;
      eng_len_q     <= '0;
      chunks_q      <= '0;
      eng_run_q     <= 1'b0;
      job_done_q    <= 1'b0;
      job_aborted_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      eng_addr_q    <= eng_addr_d;
      remain_q      <= remain_d;
      eng_len_q     <= eng_len_d;
      chunks_q      <= chunks_d;
      eng_run_q     <= eng_run_d;
      job_done_q    <= job_done_d;
      job_aborted_q <= job_aborted_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    eng_addr_d    = eng_addr_q;
    remain_d      = remain_q;
    eng_len_d     = eng_len_q;
    chunks_d      = chunks_q;
    eng_run_d     = 1'b0;
    job_done_d    = 1'b0;
    job_aborted_d = 1'b0;
    case (state_q)
      // a start landing on the job_done cycle is still part of the old job
      IDLE: if (start && !job_done_q) begin
        chunks_d = '0;
        if (job_len != '0) begin
          state_d    = LAUNCH;
          cur_addr_d = job_clAddr;
          remain_d   = job_len;
        end else begin
          job_done_d = 1'b1;
        end
      end
      LAUNCH: begin
        eng_addr_d = cur_addr_q;
        eng_len_d  = (remain_q > MAX_LEN) ? MAX_LEN : remain_q;
        eng_run_d  = 1'b1;
        state_d    = SETTLE;
      end
      SETTLE: state_d = WAIT;
      WAIT: if (eng_done) begin
        cur_addr_d = cur_addr_q + ADDR_W'(eng_len_q);
        remain_d   = remain_q - eng_len_q;
        chunks_d   = &chunks_q ? chunks_q : chunks_q + 32'd1;
        state_d    = (remain_d == '0 || abort) ? FINISH : LAUNCH;
      end
      FINISH: begin
        job_done_d    = 1'b1;
        job_aborted_d = remain_q != '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy        = state_q != IDLE;
  assign job_done    = job_done_q;
  assign job_aborted = job_aborted_q;
  assign chunks_done = chunks_q;
  assign eng_run     = eng_run_q;
  assign eng_clAddr  = eng_addr_q;
  assign eng_len     = eng_len_q;
endmodule
